// File: rtl/aes_sbox_sched.sv
// aes_sbox_sched: one synchronous S-box RAM shared between
// SubWord (key expansion) and SubBytes (cipher round) requests.
module aes_sbox_sched #(
  parameter int KW_BYTES = 4,
  parameter int ST_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    kw_start,
  input  logic [8*KW_BYTES-1:0]   kw_in,
  output logic                    kw_done,
  output logic [8*KW_BYTES-1:0]   kw_out,
  input  logic                    st_start,
  input  logic [8*ST_BYTES-1:0]   st_in,
  output logic                    st_done,
  output logic [8*ST_BYTES-1:0]   st_out,
  output logic                    busy,
  output logic [7:0]              sb_a,
  input  logic [7:0]              sb_y
);

  localparam int KW_AW = $clog2(KW_BYTES);
  localparam int ST_AW = $clog2(ST_BYTES);
  localparam int CW    = $clog2(ST_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                  state;
  logic                    sel;
  logic [CW-1:0]           cnt;
  logic                    pend_kw;
  logic                    pend_st;
  logic [8*KW_BYTES-1:0]   kw_lat;
  logic [8*ST_BYTES-1:0]   st_lat;

  logic [CW-1:0]           n_last;
  logic [KW_AW-1:0]        kw_rd;
  logic [ST_AW-1:0]        st_rd;
  logic [KW_AW-1:0]        kw_wr;
  logic [ST_AW-1:0]        st_wr;

  // byte lane k sits at packed byte index (BYTES-1-k)
  assign n_last = sel ? CW'(ST_BYTES) : CW'(KW_BYTES);
  assign kw_rd  = KW_AW'(KW_BYTES - 1) - cnt[KW_AW-1:0];
  assign st_rd  = ST_AW'(ST_BYTES - 1) - cnt[ST_AW-1:0];
  assign kw_wr  = KW_AW'(KW_BYTES) - cnt[KW_AW-1:0];
  assign st_wr  = ST_AW'(ST_BYTES) - cnt[ST_AW-1:0];
  assign busy   = (state != IDLE);

  // address the selected byte of the active latch, else 0
  always_comb begin
    sb_a = 8'h00;
    if (state == RUN && cnt < n_last) begin
      if (sel)
        sb_a = st_lat[{st_rd, 3'b000} +: 8];
      else
        sb_a = kw_lat[{kw_rd, 3'b000} +: 8];
    end
  end

  // request latching, arbitration and result capture
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      sel     <= 1'b0;
      cnt     <= '0;
      pend_kw <= 1'b0;
      pend_st <= 1'b0;
      kw_lat  <= '0;
      st_lat  <= '0;
      kw_out  <= '0;
      st_out  <= '0;
      kw_done <= 1'b0;
      st_done <= 1'b0;
    end else begin
      kw_done <= 1'b0;
      st_done <= 1'b0;
      if (kw_start) begin
        kw_lat  <= kw_in;
        pend_kw <= 1'b1;
      end
      if (st_start) begin
        st_lat  <= st_in;
        pend_st <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (pend_kw || kw_start) begin
            sel     <= 1'b0;
            pend_kw <= 1'b0;
            cnt     <= '0;
            state   <= RUN;
          end else if (pend_st || st_start) begin
            sel     <= 1'b1;
            pend_st <= 1'b0;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (cnt != '0) begin
            if (sel)
              st_out[{st_wr, 3'b000} +: 8] <= sb_y;
            else
              kw_out[{kw_wr, 3'b000} +: 8] <= sb_y;
          end
          if (cnt == n_last) begin
            state <= DONE;
            if (sel)
              st_done <= 1'b1;
            else
              kw_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
